// File: rtl/tx_message_scheduler_pkg.sv
// Shared CAN transmit-path definitions: message layout and scheduler state encoding.
package tx_message_scheduler_pkg;

    localparam int unsigned MSG_W  = 128;
    localparam int unsigned ID_HI  = 127;
    localparam int unsigned ID_LO  = 96;
    localparam int unsigned DLC_HI = 95;
    localparam int unsigned DLC_LO = 64;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StCapture = 3'd2,
        StRequest = 3'd3,
        StRearm   = 3'd4
    } tx_sched_state_t;

endpackage

// File: rtl/tx_message_scheduler_if.sv
// Bundle between the TX scheduler, the register-side FIFO/HPB and the bit-stream engine.
interface tx_message_scheduler_if;
    import tx_message_scheduler_pkg::*;

    logic             i_tx_enable;
    logic             i_tx_empty;
    logic             o_tx_r_en;
    logic [MSG_W-1:0] i_tx_fifo_r_data;
    logic             i_txhpb_valid;
    logic [MSG_W-1:0] i_txhpb_data;
    logic             o_hpb_ack;
    logic [MSG_W-1:0] o_tx_message;
    logic             o_tx_req;
    logic             i_tx_done;
    logic             i_tx_arb_lost;
    logic             i_tx_err;
    logic             o_tx_ok;
    logic             o_arb_lost;
    logic             o_tx_abort;
    logic             o_txbsy;
    logic [7:0]       o_retry_cnt;

    // Scheduler side.
    modport master (
        input  i_tx_enable, i_tx_empty, i_tx_fifo_r_data, i_txhpb_valid, i_txhpb_data,
        input  i_tx_done, i_tx_arb_lost, i_tx_err,
        output o_tx_r_en, o_hpb_ack, o_tx_message, o_tx_req, o_tx_ok, o_arb_lost,
        output o_tx_abort, o_txbsy, o_retry_cnt
    );

    // Environment side (FIFO, HPB, engine).
    modport slave (
        output i_tx_enable, i_tx_empty, i_tx_fifo_r_data, i_txhpb_valid, i_txhpb_data,
        output i_tx_done, i_tx_arb_lost, i_tx_err,
        input  o_tx_r_en, o_hpb_ack, o_tx_message, o_tx_req, o_tx_ok, o_arb_lost,
        input  o_tx_abort, o_txbsy, o_retry_cnt
    );

endinterface

// File: rtl/tx_message_scheduler.sv
// Picks the next TX message (HPB before FIFO), holds it, and runs the request/outcome
// handshake with the bit-stream engine including retransmission and abort.
module tx_message_scheduler
    import tx_message_scheduler_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 8
) (
    input  logic                          i_sys_clk,
    input  logic                          i_reset,
    tx_message_scheduler_if.master        bus
);

    tx_sched_state_t  state_q, state_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       retry_inc;
    logic             tx_req_q, tx_req_d;
    logic             r_en_q, r_en_d;
    logic             hpb_ack_q, hpb_ack_d;
    logic             tx_ok_q, tx_ok_d;
    logic             arb_lost_q, arb_lost_d;
    logic             abort_q, abort_d;
    logic             txbsy_q, txbsy_d;

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        retry_d    = retry_q;
        hpb_ack_d  = 1'b0;
        tx_ok_d    = 1'b0;
        arb_lost_d = 1'b0;
        abort_d    = 1'b0;
        // Saturating increment; only reachable at 255 when MAX_RETRY is 0 or above 255.
        retry_inc  = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

        unique case (state_q)
            StIdle: begin
                if (bus.i_tx_enable) begin
                    if (bus.i_txhpb_valid) begin
                        msg_d     = bus.i_txhpb_data;
                        retry_d   = 8'd0;
                        hpb_ack_d = 1'b1;
                        state_d   = StRequest;
                    end else if (!bus.i_tx_empty) begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                state_d = StCapture;
            end
            StCapture: begin
                msg_d   = bus.i_tx_fifo_r_data;
                retry_d = 8'd0;
                state_d = StRequest;
            end
            StRequest: begin
                if (bus.i_tx_done) begin
                    tx_ok_d = 1'b1;
                    state_d = StIdle;
                end else if (bus.i_tx_err) begin
                    retry_d = retry_inc;
                    if (MAX_RETRY != 0 && 32'(retry_inc) == MAX_RETRY) begin
                        abort_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StRearm;
                    end
                end else if (bus.i_tx_arb_lost) begin
                    arb_lost_d = 1'b1;
                    state_d    = StRearm;
                end
            end
            StRearm: begin
                state_d = StRequest;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered versions of what the next state implies.
        tx_req_d = (state_d == StRequest);
        r_en_d   = (state_d == StFetch);
        txbsy_d  = (state_d != StIdle);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            msg_q      <= '0;
            retry_q    <= 8'd0;
            tx_req_q   <= 1'b0;
            r_en_q     <= 1'b0;
            hpb_ack_q  <= 1'b0;
            tx_ok_q    <= 1'b0;
            arb_lost_q <= 1'b0;
            abort_q    <= 1'b0;
            txbsy_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            retry_q    <= retry_d;
            tx_req_q   <= tx_req_d;
            r_en_q     <= r_en_d;
            hpb_ack_q  <= hpb_ack_d;
            tx_ok_q    <= tx_ok_d;
            arb_lost_q <= arb_lost_d;
            abort_q    <= abort_d;
            txbsy_q    <= txbsy_d;
        end
    end

    assign bus.o_tx_r_en    = r_en_q;
    assign bus.o_hpb_ack    = hpb_ack_q;
    assign bus.o_tx_message = msg_q;
    assign bus.o_tx_req     = tx_req_q;
    assign bus.o_tx_ok      = tx_ok_q;
    assign bus.o_arb_lost   = arb_lost_q;
    assign bus.o_tx_abort   = abort_q;
    assign bus.o_txbsy      = txbsy_q;
    assign bus.o_retry_cnt  = retry_q;

endmodule

// File: tb/tb_tx_message_scheduler.sv
// Cycle-by-cycle directed vectors for the TX scheduler, plus a mid-request reset sequence.
module tb_tx_message_scheduler;
    import tx_message_scheduler_pkg::*;

    localparam int unsigned OW = 7 + 8 + MSG_W;

    // stim: {en, empty, hpb_valid, done, arb_lost, err}
    // resp: {req, r_en, hpb_ack, ok, arb_lost, abort, txbsy}
    typedef struct packed {
        logic [5:0] stim;
        logic [6:0] resp;
        logic [7:0] retry;
        logic [2:0] msel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_message_scheduler_if bus_if ();

    tx_message_scheduler #(.MAX_RETRY(3)) dut (
        .i_sys_clk (clk),
        .i_reset   (rst),
        .bus       (bus_if)
    );

    logic [MSG_W-1:0] msg_tab [5];
    logic [MSG_W-1:0] fifo_rd = '0;
    int               rd_ptr  = 0;
    int               n_total = 0;
    int               n_pass  = 0;
    vec_t             tbl [$];

    // FIFO model: one-cycle read latency, entries are msg_tab[2..4].
    always @(posedge clk) begin
        if (bus_if.o_tx_r_en) begin
            fifo_rd <= (rd_ptr < 3) ? msg_tab[rd_ptr + 2] : '0;
            rd_ptr  <= rd_ptr + 1;
        end
    end
    assign bus_if.i_tx_fifo_r_data = fifo_rd;

    function automatic vec_t mk(logic [5:0] s, logic [6:0] r, logic [7:0] c, logic [2:0] m);
        vec_t v;
        v.stim  = s;
        v.resp  = r;
        v.retry = c;
        v.msel  = m;
        return v;
    endfunction

    function automatic logic [OW-1:0] act_vec();
        return {bus_if.o_tx_req, bus_if.o_tx_r_en, bus_if.o_hpb_ack, bus_if.o_tx_ok,
                bus_if.o_arb_lost, bus_if.o_tx_abort, bus_if.o_txbsy, bus_if.o_retry_cnt,
                bus_if.o_tx_message};
    endfunction

    task automatic chk(string nm, logic [OW-1:0] act, logic [OW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(logic [5:0] s);
        {bus_if.i_tx_enable, bus_if.i_tx_empty, bus_if.i_txhpb_valid,
         bus_if.i_tx_done, bus_if.i_tx_arb_lost, bus_if.i_tx_err} = s;
    endtask

    initial begin
        msg_tab[0] = '0;
        msg_tab[1] = 128'hA5;
        msg_tab[2] = {32'h1000_0001, 32'h0000_0008, 64'h0123_4567_89AB_CDEF};
        msg_tab[3] = {32'h2000_0002, 32'h0000_0004, 64'h0000_0000_CAFE_F00D};
        msg_tab[4] = {32'h3000_0003, 32'h0000_0002, 64'h0000_0000_0000_BEEF};
        bus_if.i_txhpb_data = 128'hA5;
        drive(6'b000000);

        // HPB path with FIFO empty; done four cycles into the request.
        tbl.push_back(mk(6'b111000, 7'b1010001, 8'd0, 3'd1));
        tbl.push_back(mk(6'b110000, 7'b1000001, 8'd0, 3'd1));
        tbl.push_back(mk(6'b110000, 7'b1000001, 8'd0, 3'd1));
        tbl.push_back(mk(6'b110000, 7'b1000001, 8'd0, 3'd1));
        tbl.push_back(mk(6'b110100, 7'b0001000, 8'd0, 3'd1));
        tbl.push_back(mk(6'b110000, 7'b0000000, 8'd0, 3'd1));
        // HPB and FIFO together: HPB first, then a single FIFO fetch.
        tbl.push_back(mk(6'b101000, 7'b1010001, 8'd0, 3'd1));
        tbl.push_back(mk(6'b100000, 7'b1000001, 8'd0, 3'd1));
        tbl.push_back(mk(6'b100100, 7'b0001000, 8'd0, 3'd1));
        tbl.push_back(mk(6'b100000, 7'b0100001, 8'd0, 3'd1));
        tbl.push_back(mk(6'b110000, 7'b0000001, 8'd0, 3'd1));
        tbl.push_back(mk(6'b110000, 7'b1000001, 8'd0, 3'd2));
        // Three arbitration losses (HPB valid meanwhile must not preempt), then done.
        tbl.push_back(mk(6'b110010, 7'b0000101, 8'd0, 3'd2));
        tbl.push_back(mk(6'b111000, 7'b1000001, 8'd0, 3'd2));
        tbl.push_back(mk(6'b111010, 7'b0000101, 8'd0, 3'd2));
        tbl.push_back(mk(6'b111000, 7'b1000001, 8'd0, 3'd2));
        tbl.push_back(mk(6'b111010, 7'b0000101, 8'd0, 3'd2));
        tbl.push_back(mk(6'b111000, 7'b1000001, 8'd0, 3'd2));
        tbl.push_back(mk(6'b110100, 7'b0001000, 8'd0, 3'd2));
        // Disabled: no selection even with HPB valid and FIFO non-empty.
        tbl.push_back(mk(6'b001000, 7'b0000000, 8'd0, 3'd2));
        // Error retries up to abort; err during REARM is ignored.
        tbl.push_back(mk(6'b100000, 7'b0100001, 8'd0, 3'd2));
        tbl.push_back(mk(6'b110000, 7'b0000001, 8'd0, 3'd2));
        tbl.push_back(mk(6'b110000, 7'b1000001, 8'd0, 3'd3));
        tbl.push_back(mk(6'b110001, 7'b0000001, 8'd1, 3'd3));
        tbl.push_back(mk(6'b110001, 7'b1000001, 8'd1, 3'd3));
        tbl.push_back(mk(6'b110001, 7'b0000001, 8'd2, 3'd3));
        tbl.push_back(mk(6'b110000, 7'b1000001, 8'd2, 3'd3));
        tbl.push_back(mk(6'b110001, 7'b0000010, 8'd3, 3'd3));
        // Next FIFO message after abort; capture clears the retry count.
        tbl.push_back(mk(6'b100000, 7'b0100001, 8'd3, 3'd3));
        tbl.push_back(mk(6'b110000, 7'b0000001, 8'd3, 3'd3));
        tbl.push_back(mk(6'b110000, 7'b1000001, 8'd0, 3'd4));
        tbl.push_back(mk(6'b110001, 7'b0000001, 8'd1, 3'd4));
        tbl.push_back(mk(6'b110000, 7'b1000001, 8'd1, 3'd4));
        // Done and err together: ok only, count unchanged.
        tbl.push_back(mk(6'b110101, 7'b0001000, 8'd1, 3'd4));
        tbl.push_back(mk(6'b110000, 7'b0000000, 8'd1, 3'd4));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", act_vec(), '0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stim);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", i), act_vec(),
                {tbl[i].resp, tbl[i].retry, msg_tab[tbl[i].msel]});
        end

        // Reset while a request is outstanding, with a done pulse in the same cycle.
        bus_if.i_txhpb_data = 128'hDEAD_BEEF;
        drive(6'b111000);
        @(posedge clk);
        #1;
        chk("pre_reset_req", act_vec(), {7'b1010001, 8'd0, 128'hDEAD_BEEF});
        drive(6'b000100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(6'b000000);
        chk("mid_reset_clear", act_vec(), '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_reset_idle%0d", i), act_vec(), '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
